// File: rtl/snake_frame_packer.sv
// Producer of the 740-bit snake_data bus: shadow register set published atomically at vblank start.
// Optional macro HEARTS_DECAY_EN: active heartsTimer counts down once per frame while stage==2.
module snake_frame_packer (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    input  logic         vs_in,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         commit_req,
    output logic         commit_busy,
    output logic         commit_ack,
    output logic [739:0] snake_data
);

    localparam int unsigned BODY_SLOTS = 10;
    localparam int unsigned SLOT_W     = 11;
    localparam int unsigned BODY_W     = BODY_SLOTS * SLOT_W;
    localparam int unsigned DIR_N      = 100;
    localparam int unsigned DIR_W      = 2 * DIR_N;
    localparam int unsigned WORD_W     = 32;
    localparam logic [10:0] SENTINEL   = 11'h7FF;

    localparam logic [3:0] A_STAGE  = 4'd0;
    localparam logic [3:0] A_H1POS  = 4'd1;
    localparam logic [3:0] A_H2POS  = 4'd2;
    localparam logic [3:0] A_LEN1   = 4'd3;
    localparam logic [3:0] A_LEN2   = 4'd4;
    localparam logic [3:0] A_HEAD1  = 4'd5;
    localparam logic [3:0] A_HEAD2  = 4'd6;
    localparam logic [3:0] A_APPLE  = 4'd7;
    localparam logic [3:0] A_HEARTS = 4'd8;
    localparam logic [3:0] A_BCLR   = 4'd9;
    localparam logic [3:0] A_DIR    = 4'd10;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Shadow copy, written by the game processor
    logic [WORD_W-1:0] sh_stage, sh_h1pos, sh_h2pos, sh_len1, sh_len2;
    logic [WORD_W-1:0] sh_head1, sh_head2, sh_apple, sh_hearts;
    logic [DIR_W-1:0]  sh_dir;
    logic [SLOT_W-1:0] sh_body [BODY_SLOTS];

    // Active copy, seen by the display
    logic [WORD_W-1:0] act_stage, act_h1pos, act_h2pos, act_len1, act_len2;
    logic [WORD_W-1:0] act_head1, act_head2, act_apple, act_hearts;
    logic [DIR_W-1:0]  act_dir;
    logic [BODY_W-1:0] act_body;

    logic [0:0] state, next_state;
    logic       vs_prev;
    logic       vs_fall_c;
    logic       commit_fire_c;
    logic [3:0] len_sat_c;
    logic [BODY_W-1:0] masked_body_c;
    logic [6:0] dir_idx_c;

    assign vs_fall_c = vs_prev & ~vs_in;
    assign dir_idx_c = wr_data[6:0];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= vs_in;
        end
    end

    // Commit FSM: state register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Commit FSM: next state; a request coinciding with vblank start commits immediately
    always_comb begin
        next_state    = state;
        commit_fire_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    if (vs_fall_c) begin
                        commit_fire_c = 1'b1;
                    end else begin
                        next_state = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (vs_fall_c) begin
                    commit_fire_c = 1'b1;
                    next_state    = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign commit_busy = (state == ST_PENDING);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            commit_ack <= 1'b0;
        end else begin
            commit_ack <= commit_fire_c;
        end
    end

    // Slot k is live only while k < length1-1; length1 saturates so huge values expose all slots
    always_comb begin
        masked_body_c = '0;
        len_sat_c     = (sh_len1 > 32'd11) ? 4'd11 : sh_len1[3:0];
        for (int k = 0; k < BODY_SLOTS; k++) begin
            if (4'(k + 1) < len_sat_c) begin
                masked_body_c[SLOT_W*k +: SLOT_W] = sh_body[k];
            end else begin
                masked_body_c[SLOT_W*k +: SLOT_W] = SENTINEL;
            end
        end
    end

    // Shadow write port
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sh_stage  <= '0;
            sh_h1pos  <= '0;
            sh_h2pos  <= '0;
            sh_len1   <= '0;
            sh_len2   <= '0;
            sh_head1  <= '0;
            sh_head2  <= '0;
            sh_apple  <= '0;
            sh_hearts <= '0;
            sh_dir    <= '0;
            for (int k = 0; k < BODY_SLOTS; k++) begin
                sh_body[k] <= SENTINEL;
            end
        end else if (wr_en) begin
            case (wr_addr)
                A_STAGE:  sh_stage <= wr_data;
                A_H1POS: begin
                    sh_h1pos   <= wr_data;
                    sh_body[0] <= sh_h1pos[SLOT_W-1:0];
                    for (int k = 1; k < BODY_SLOTS; k++) begin
                        sh_body[k] <= sh_body[k-1];
                    end
                end
                A_H2POS:  sh_h2pos  <= wr_data;
                A_LEN1:   sh_len1   <= wr_data;
                A_LEN2:   sh_len2   <= wr_data;
                A_HEAD1:  sh_head1  <= wr_data;
                A_HEAD2:  sh_head2  <= wr_data;
                A_APPLE:  sh_apple  <= wr_data;
                A_HEARTS: sh_hearts <= wr_data;
                A_BCLR: begin
                    for (int k = 0; k < BODY_SLOTS; k++) begin
                        sh_body[k] <= SENTINEL;
                    end
                end
                A_DIR: begin
                    for (int i = 0; i < DIR_N; i++) begin
                        if (dir_idx_c == 7'(i)) begin
                            sh_dir[2*i +: 2] <= wr_data[9:8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Active copy: atomic load on commit (reads pre-write shadow values)
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            act_stage  <= '0;
            act_h1pos  <= '0;
            act_h2pos  <= '0;
            act_len1   <= '0;
            act_len2   <= '0;
            act_head1  <= '0;
            act_head2  <= '0;
            act_apple  <= '0;
            act_hearts <= '0;
            act_dir    <= '0;
            act_body   <= {BODY_SLOTS{SENTINEL}};
        end else if (commit_fire_c) begin
            act_stage  <= sh_stage;
            act_h1pos  <= sh_h1pos;
            act_h2pos  <= sh_h2pos;
            act_len1   <= sh_len1;
            act_len2   <= sh_len2;
            act_head1  <= sh_head1;
            act_head2  <= sh_head2;
            act_apple  <= sh_apple;
            act_hearts <= sh_hearts;
            act_dir    <= sh_dir;
            act_body   <= masked_body_c;
`ifdef HEARTS_DECAY_EN
        end else if (vs_fall_c && (act_stage == 32'd2) && (act_hearts != '0)) begin
            act_hearts <= act_hearts - 32'd1;
`endif
        end
    end

    assign snake_data = {110'b0, act_body, 32'b0,
                         act_hearts, act_apple, act_head2, act_head1, act_stage,
                         act_len2, act_len1, act_h2pos, act_h1pos, act_dir};

endmodule

// File: tb/tb_snake_frame_packer.sv
// Directed self-checking bench for snake_frame_packer (honours HEARTS_DECAY_EN if defined).
module tb_snake_frame_packer;

    logic         clk;
    logic         rst_n;
    logic         vs_in;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         commit_req;
    logic         commit_busy;
    logic         commit_ack;
    logic [739:0] snake_data;

    logic [739:0] exp_bus;
    int unsigned  n_assert;
    int unsigned  n_fail;
    int unsigned  ack_cnt;

    snake_frame_packer dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .vs_in       (vs_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_busy (commit_busy),
        .commit_ack  (commit_ack),
        .snake_data  (snake_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bus(input string tag);
        n_assert++;
        assert (snake_data === exp_bus) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, snake_data, exp_bus);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int unsigned obs, input int unsigned expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic req();
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
    endtask

    task automatic frame();
        vs_in = 1'b0;
        @(negedge clk);
        vs_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_exp();
        exp_bus = '0;
        for (int k = 0; k < 10; k++) exp_bus[520 + 11*k +: 11] = 11'h7FF;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst_n = 1'b0;
        vs_in = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit_req = 1'b0;
        reset_exp();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk_bus("reset_bus");
        chk_bit("reset_busy", commit_busy, 1'b0);
        chk_bit("reset_ack", commit_ack, 1'b0);

        // Deferred commit of stage and apple
        wr(4'd0, 32'd2);
        wr(4'd7, 32'd425);
        req();
        repeat (3) @(negedge clk);
        chk_bus("pending_bus_unchanged");
        chk_bit("pending_busy", commit_busy, 1'b1);
        vs_in = 1'b0;
        @(negedge clk);
        exp_bus[359:328] = 32'd2;
        exp_bus[455:424] = 32'd425;
        chk_bus("commit1_bus");
        chk_bit("commit1_ack", commit_ack, 1'b1);
        chk_bit("commit1_busy", commit_busy, 1'b0);
        vs_in = 1'b1;
        @(negedge clk);
        chk_bit("commit1_ack_drop", commit_ack, 1'b0);

        // Body queue and masking
        wr(4'd3, 32'd4);
        wr(4'd1, 32'd100);
        wr(4'd1, 32'd101);
        wr(4'd1, 32'd102);
        wr(4'd1, 32'd103);
        req();
        frame();
        exp_bus[295:264] = 32'd4;
        exp_bus[231:200] = 32'd103;
        exp_bus[520 +: 11] = 11'd102;
        exp_bus[531 +: 11] = 11'd101;
        exp_bus[542 +: 11] = 11'd100;
        chk_bus("body_len4");
        wr(4'd3, 32'd1);
        req();
        frame();
        exp_bus[295:264] = 32'd1;
        for (int k = 0; k < 3; k++) exp_bus[520 + 11*k +: 11] = 11'h7FF;
        chk_bus("body_len1_masked");

        // Three requests merge into one commit
        req();
        @(negedge clk);
        req();
        req();
        vs_in = 1'b0;
        @(negedge clk);
        vs_in = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (commit_ack) ack_cnt++;
            @(negedge clk);
        end
        chk_int("merged_ack_count", ack_cnt, 1);
        chk_bus("merged_bus");

        // Request + write in the vs_fall cycle: commit uses pre-write shadow
        commit_req = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = 32'd7;
        vs_in = 1'b0;
        @(negedge clk);
        commit_req = 1'b0;
        wr_en = 1'b0;
        vs_in = 1'b1;
        chk_bit("same_cycle_ack", commit_ack, 1'b1);
        chk_bus("write_in_commit_cycle_excluded");
        @(negedge clk);
        req();
        frame();
        exp_bus[359:328] = 32'd7;
        chk_bus("write_visible_next_commit");

        // Direction writes
        wr(4'd10, 32'h0000_0305);
        req();
        frame();
        exp_bus[11:10] = 2'b11;
        chk_bus("dir_idx5");
        wr(4'd10, 32'h0000_0378);
        req();
        frame();
        chk_bus("dir_idx120_ignored");

        // Hearts timer, with or without decay
        wr(4'd0, 32'd2);
        wr(4'd8, 32'd2);
        req();
        frame();
        exp_bus[359:328] = 32'd2;
        exp_bus[487:456] = 32'd2;
        chk_bus("hearts_commit");
        frame();
`ifdef HEARTS_DECAY_EN
        exp_bus[487:456] = 32'd1;
`endif
        chk_bus("hearts_frame1");
        frame();
`ifdef HEARTS_DECAY_EN
        exp_bus[487:456] = 32'd0;
`endif
        chk_bus("hearts_frame2");
        frame();
        chk_bus("hearts_frame3");

        // Reset while pending drops the request
        wr(4'd0, 32'd9);
        req();
        chk_bit("prereset_busy", commit_busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("postreset_busy", commit_busy, 1'b0);
        vs_in = 1'b0;
        @(negedge clk);
        vs_in = 1'b1;
        chk_bit("postreset_no_ack", commit_ack, 1'b0);
        reset_exp();
        chk_bus("postreset_bus");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
